// File: rtl/l2_cache_control.sv
// Control FSM for the 4-way, 8-set L2 cache: lookup, hit service, victim writeback and line fill.
// Optional performance counters (hit/miss/writeback) are enabled with `define L2_PERF_CNT_EN.
module l2_cache_control #(
  parameter int WAYS = 4
`ifdef L2_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  input  logic [WAYS-1:0] way_hit,
  input  logic [WAYS-1:0] way_valid,
  input  logic [WAYS-1:0] way_dirty,
  output logic            lru_read,
  output logic            lru_load,
  output logic [WAYS-1:0] lru_hit,
  input  logic [1:0]      lru_out,
  output logic [WAYS-1:0] data_load,
  output logic [WAYS-1:0] tag_load,
  output logic [WAYS-1:0] dirty_set,
  output logic [WAYS-1:0] dirty_clr,
  output logic            din_sel,
  output logic            addr_sel,
  output logic            pmem_read,
  output logic            pmem_write,
  input  logic            pmem_resp
`ifdef L2_PERF_CNT_EN
  , output logic [CNT_W-1:0] hit_cnt
  , output logic [CNT_W-1:0] miss_cnt
  , output logic [CNT_W-1:0] wb_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WRITEBACK, FILL} state_t;

  state_t          state, state_nxt;
  logic [1:0]      victim;
  logic            victim_we;
  logic            req;
  logic            hit_onehot;
  logic            victim_dirty;
  logic [WAYS-1:0] victim_oh;

  assign req          = mem_read | mem_write;
  // A multi-way match is a datapath fault; treat it as a miss rather than corrupt two ways.
  assign hit_onehot   = (way_hit != '0) && ((way_hit & (way_hit - 1'b1)) == '0);
  assign victim_dirty = way_valid[lru_out] & way_dirty[lru_out];
  assign victim_oh    = {{(WAYS-1){1'b0}}, 1'b1} << victim;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      victim <= '0;
    end else begin
      state <= state_nxt;
      if (victim_we) victim <= lru_out;
    end
  end

  always_comb begin
    state_nxt  = state;
    victim_we  = 1'b0;
    mem_resp   = 1'b0;
    lru_read   = 1'b0;
    lru_load   = 1'b0;
    lru_hit    = '0;
    data_load  = '0;
    tag_load   = '0;
    dirty_set  = '0;
    dirty_clr  = '0;
    din_sel    = 1'b0;
    addr_sel   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = LOOKUP;
      LOOKUP: begin
        lru_read  = 1'b1;
        state_nxt = COMPARE;
      end
      COMPARE: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (hit_onehot) begin
          lru_read  = 1'b1;
          lru_load  = 1'b1;
          lru_hit   = way_hit;
          mem_resp  = 1'b1;
          if (mem_write) begin
            data_load = way_hit;
            dirty_set = way_hit;
          end
          state_nxt = IDLE;
        end else begin
          victim_we = 1'b1;
          state_nxt = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        if (pmem_resp) state_nxt = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_load = victim_oh;
          tag_load  = victim_oh;
          dirty_clr = victim_oh;
          din_sel   = 1'b1;
          // The line is installed even if L1 gave up; only a live request re-looks up.
          state_nxt = req ? LOOKUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  logic hit_evt, miss_evt, wb_evt;

  assign hit_evt  = (state == COMPARE) && req && hit_onehot;
  assign miss_evt = (state == COMPARE) && req && !hit_onehot;
  assign wb_evt   = miss_evt && victim_dirty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_evt  && (hit_cnt  != '1)) hit_cnt  <= hit_cnt  + 1'b1;
      if (miss_evt && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      if (wb_evt   && (wb_cnt   != '1)) wb_cnt   <= wb_cnt   + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Scoreboard bench for l2_cache_control: directed scenarios push expected output cycles,
// a negedge monitor pops and compares every cycle on which any control output is active.
module tb_l2_cache_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, mem_write, mem_resp;
  logic [3:0] way_hit, way_valid, way_dirty;
  logic       lru_read, lru_load;
  logic [3:0] lru_hit;
  logic [1:0] lru_out;
  logic [3:0] data_load, tag_load, dirty_set, dirty_clr;
  logic       din_sel, addr_sel, pmem_read, pmem_write, pmem_resp;
`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  l2_cache_control dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
    .lru_read(lru_read), .lru_load(lru_load), .lru_hit(lru_hit), .lru_out(lru_out),
    .data_load(data_load), .tag_load(tag_load), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .din_sel(din_sel), .addr_sel(addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp)
`ifdef L2_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // {mem_resp,lru_read,lru_load,lru_hit,data_load,tag_load,dirty_set,dirty_clr,din_sel,addr_sel,pmem_read,pmem_write}
  logic [26:0] obs;
  assign obs = {mem_resp, lru_read, lru_load, lru_hit, data_load, tag_load, dirty_set,
                dirty_clr, din_sel, addr_sel, pmem_read, pmem_write};

  typedef struct {
    int          cyc;
    logic [26:0] v;
    string       name;
  } exp_t;
  exp_t expq[$];

  function automatic logic [26:0] f_lookup();
    return 27'h1 << 25;
  endfunction
  function automatic logic [26:0] f_hit(logic [3:0] w, logic wr);
    return {1'b1, 1'b1, 1'b1, w, (wr ? w : 4'b0), 4'b0, (wr ? w : 4'b0), 4'b0, 4'b0};
  endfunction
  function automatic logic [26:0] f_fill();
    return 27'b10;
  endfunction
  function automatic logic [26:0] f_wb();
    return 27'b101;
  endfunction
  function automatic logic [26:0] f_install(logic [3:0] w);
    return {3'b0, 4'b0, w, w, 4'b0, w, 1'b1, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic push(int c, logic [26:0] v, string n);
    exp_t e;
    e.cyc = c; e.v = v; e.name = n;
    expq.push_back(e);
  endtask

  task automatic step(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        exp_t e;
        e = expq.pop_front();
        checks++;
        errors++;
        $display("FAIL %s missing at cyc %0d expected=%h got=nothing", e.name, e.cyc, e.v);
      end
      if (obs !== 27'b0) begin
        checks++;
        if (expq.size() == 0 || expq[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d got=%h expected=none", cyc, obs);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (e.v !== obs) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, obs, e.v);
          end
        end
      end
    end
  end

  initial begin
    int t;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    way_hit = '0; way_valid = '0; way_dirty = '0; lru_out = '0;
    step(3);
    chk("reset_outputs", {5'b0, obs}, 32'h0);
`ifdef L2_PERF_CNT_EN
    chk("reset_hit_cnt", hit_cnt, 0);
`endif
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(1);

    // read hit on way 2
    t = cyc;
    push(t+1, f_lookup(), "rd_hit_lookup");
    push(t+2, f_hit(4'b0100, 1'b0), "rd_hit_resp");
    mem_read = 1'b1; way_hit = 4'b0100;
    step(3); mem_read = 1'b0; way_hit = '0;
    step(1);

    // write hit on way 0
    t = cyc;
    push(t+1, f_lookup(), "wr_hit_lookup");
    push(t+2, f_hit(4'b0001, 1'b1), "wr_hit_resp");
    mem_write = 1'b1; way_hit = 4'b0001;
    step(3); mem_write = 1'b0; way_hit = '0;
    step(1);

    // read miss, clean victim 2, fill latency 5, re-lookup hit
    t = cyc;
    push(t+1, f_lookup(), "rd_miss_lookup");
    for (int c = 3; c <= 7; c++) push(t+c, f_fill(), "rd_miss_fill");
    push(t+8, f_install(4'b0100), "rd_miss_install");
    push(t+9, f_lookup(), "rd_miss_relookup");
    push(t+10, f_hit(4'b0100, 1'b0), "rd_miss_resp");
    lru_out = 2'd2; way_valid = 4'b1111; way_dirty = 4'b1000; mem_read = 1'b1;
    step(8); pmem_resp = 1'b1;
    step(1); pmem_resp = 1'b0; way_hit = 4'b0100;
    step(2); mem_read = 1'b0; way_hit = '0;
    step(1);

    // simultaneous read+write, dirty victim 1: writeback then fill, serviced as write
    t = cyc;
    push(t+1, f_lookup(), "wr_miss_lookup");
    for (int c = 3; c <= 6; c++) push(t+c, f_wb(), "wr_miss_wb");
    for (int c = 7; c <= 10; c++) push(t+c, f_fill(), "wr_miss_fill");
    push(t+11, f_install(4'b0010), "wr_miss_install");
    push(t+12, f_lookup(), "wr_miss_relookup");
    push(t+13, f_hit(4'b0010, 1'b1), "wr_miss_resp");
    lru_out = 2'd1; way_valid = 4'b0010; way_dirty = 4'b0010;
    mem_read = 1'b1; mem_write = 1'b1;
    step(6); pmem_resp = 1'b1;
    step(1); pmem_resp = 1'b0;
    step(4); pmem_resp = 1'b1;
    step(1); pmem_resp = 1'b0; way_hit = 4'b0010;
    step(2); mem_read = 1'b0; mem_write = 1'b0; way_hit = '0;
    step(1);
`ifdef L2_PERF_CNT_EN
    chk("hit_cnt_a", hit_cnt, 4);
    chk("miss_cnt_a", miss_cnt, 2);
    chk("wb_cnt_a", wb_cnt, 1);
`endif

    // request dropped during fill: line still installed, no response, back to idle
    t = cyc;
    push(t+1, f_lookup(), "drop_lookup");
    push(t+3, f_fill(), "drop_fill");
    push(t+4, f_fill(), "drop_fill");
    push(t+5, f_install(4'b0001), "drop_install");
    lru_out = 2'd0; way_valid = '0; way_dirty = '0; mem_read = 1'b1;
    step(4); mem_read = 1'b0;
    step(1); pmem_resp = 1'b1;
    step(1); pmem_resp = 1'b0;
    step(2);

    // multi-way hit treated as miss, victim 3, then real hit
    t = cyc;
    push(t+1, f_lookup(), "multi_lookup");
    push(t+3, f_fill(), "multi_fill");
    push(t+4, f_install(4'b1000), "multi_install");
    push(t+5, f_lookup(), "multi_relookup");
    push(t+6, f_hit(4'b1000, 1'b0), "multi_resp");
    lru_out = 2'd3; way_valid = 4'b1111; way_dirty = 4'b0000;
    way_hit = 4'b0011; mem_read = 1'b1;
    step(4); pmem_resp = 1'b1; way_hit = '0;
    step(1); pmem_resp = 1'b0; way_hit = 4'b1000;
    step(2); mem_read = 1'b0; way_hit = '0;
    step(1);
`ifdef L2_PERF_CNT_EN
    chk("hit_cnt_b", hit_cnt, 5);
    chk("miss_cnt_b", miss_cnt, 4);
    chk("wb_cnt_b", wb_cnt, 1);
`endif

    // reset mid-fill; late pmem_resp must be ignored
    t = cyc;
    push(t+1, f_lookup(), "rst_lookup");
    for (int c = 3; c <= 5; c++) push(t+c, f_fill(), "rst_fill");
    lru_out = 2'd0; way_valid = '0; way_dirty = '0; mem_read = 1'b1;
    step(5); rst_n = 1'b0; mem_read = 1'b0;
    step(1); rst_n = 1'b1; pmem_resp = 1'b1;
    #1 chk("rst_mid_fill_outputs", {5'b0, obs}, 32'h0);
`ifdef L2_PERF_CNT_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    step(1); pmem_resp = 1'b0;
    step(2);

    // normal read hit after reset
    t = cyc;
    push(t+1, f_lookup(), "post_rst_lookup");
    push(t+2, f_hit(4'b0010, 1'b0), "post_rst_resp");
    mem_read = 1'b1; way_hit = 4'b0010;
    step(3); mem_read = 1'b0; way_hit = '0;
    step(3);
`ifdef L2_PERF_CNT_EN
    chk("hit_cnt_c", hit_cnt, 1);
    chk("miss_cnt_c", miss_cnt, 0);
    chk("wb_cnt_c", wb_cnt, 0);
`endif

    chk("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
